axioma_dac: RTL and testbench
=============================

Name: axioma_dac

Overview:
- 10-bit memory-mapped DAC controller; the output-direction counterpart of the ADC on the same I/O bus.
- CPU writes a code into a double-buffered data register. The block loads it into the active code on an update event.
- The active code is converted to a 1-bit density stream: first-order sigma-delta by default, optional PWM. An external RC filter smooths the stream.
- Sits on the I/O bus beside the ADC and raises an interrupt when the active code is updated.

Parameters:
- ADDR_DACCON, 6'h2A, control/status register address
- ADDR_DACL, 6'h28, data low byte address
- ADDR_DACH, 6'h29, data high byte address
- ADDR_DACCONB, 6'h2B, control register B address

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  asynchronous, active-high reset
- io_addr  in  6  I/O address
- io_data_in  in  8  write data
- io_data_out  out  8  read data; combinational; 0 when io_read=0 or address unmapped
- io_read  in  1  read strobe
- io_write  in  1  write strobe, one clk per access
- dac_trigger  in  1  external auto-update trigger (synchronous, level)
- dac_out  out  1  modulated output, registered
- dac_interrupt  out  1  DACIF && DACIE
- debug_state  out  8  {state[1:0], DACEN, pending, mode, 3'b0}
- debug_code  out  10  active code

Behaviour:
- Reset: all registers, temp, buffer, active code, accumulator, counter, prescaler and pending are 0. dac_out=0, dac_interrupt=0, state DISABLED.
- DACCON bits: [7] DACEN, [6] DACUP, [5] DACATE, [4] DACIF, [3] DACIE, [2:0] DACPS.
- DACCONB bits: [5] DALAR left adjust, [0] MODE (0 sigma-delta, 1 PWM). Other bits read 0.
- 16-bit write protocol:
  - A DACH write stores the byte in a temp register.
  - A DACL write commits {temp, low} to the 10-bit buffer in the same clk.
  - DALAR=0: buffer = {temp[1:0], low}.
  - DALAR=1: buffer = {temp, low[7:6]}.
  - Reads of DACL/DACH return the buffer in the current alignment (DALAR=0: DACL=buf[7:0], DACH={6'b0,buf[9:8]}; DALAR=1: DACH=buf[9:2], DACL={buf[1:0],6'b0}).
- Prescaler: DACPS=0 gives a tick every clk; otherwise a tick every 2^DACPS clks (max /128). The counter runs only while DACEN=1.
- Update request sets pending. A request is either:
  - a DACCON write with bit6=1 while DACEN (old or new value) is 1, or
  - a rising edge of dac_trigger (registered edge detect) while DACATE=1 and DACEN=1.
  - DACUP reads 1 while pending and self-clears on load.
- Load point:
  - MODE=0: the next tick.
  - MODE=1: the tick at which the PWM counter wraps 1023->0.
  - At load: active <= buffer; pending <= 0; DACIF <= 1.
- DACIF clear: writing 1 to DACCON bit4 clears DACIF. If a set and a clear occur in the same clk, the set wins.
- States:
  - DISABLED (DACEN=0): dac_out=0; accumulator, PWM counter and pending held at 0; active code is kept.
  - RUN: enters from DISABLED on the clk after DACEN is written 1.
  - LOAD_WAIT: RUN with pending=1; returns to RUN at load.
  - Writing DACEN=0 from any state goes to DISABLED in the next clk and drops pending.
- Sigma-delta, per tick: {c, acc[9:0]} <= acc + active; dac_out <= c.
  - Density over 1024 ticks is exactly active/1024.
  - Code 0 gives constant 0.
  - Code 1023 gives 1023 ones in each 1024 ticks.
- PWM, per tick: cnt <= cnt+1 (wraps at 1023); dac_out <= (cnt < active).
- Changing MODE clears acc and cnt on the next clk.
- Register writes to unmapped addresses are ignored.

Optional Feature:
- Macro: AXIOMA_DAC_PWM_EN.
- Defined: MODE bit is implemented as described above.
- Undefined: MODE bit is tied to 0 and reads 0. No PWM counter is built. Loads always occur at the next tick.

Test Plan:
- Reset asserted mid-run with code 512 in MODE=0 -> dac_out=0, all registers read 0 next clk, debug_code=0.
- Write DACH=0x02, DACL=0x00, then DACCON=0xC0 (EN, UP, PS=0) -> DACIF=1 after 1 tick; over 1024 clks exactly 512 ones, alternating 0/1.
- DALAR=1, write DACH=0xFF, DACL=0xC0 -> DACH reads 0xFF, DACL reads 0xC0, debug_code=1023 after update; 1023 ones per 1024 ticks.
- MODE=1, active=256, DACPS=1 -> high for 512 clks in each 2048-clk period; an update to 768 requested mid-period takes effect only at the counter wrap.
- DACATE=1, DACIE=1, pulse dac_trigger high for 3 clks -> exactly one load; dac_interrupt=1; write DACCON with bit4=1 -> interrupt drops.
- A DACIF clear write in the same clk as a load -> DACIF stays 1. DACEN=0 while pending -> pending=0, dac_out=0, active code unchanged.

Source files
------------

// File: rtl/axioma_dac.sv
`default_nettype none
// ============================================================================
// Module   : axioma_dac
// Function : 10-bit I/O-mapped DAC, sigma-delta stream or PWM (AXIOMA_DAC_PWM_EN)
// Revision : 1.0
// ============================================================================
module axioma_dac #(
    parameter logic [5:0] ADDR_DACCON  = 6'h2A,
    parameter logic [5:0] ADDR_DACL    = 6'h28,
    parameter logic [5:0] ADDR_DACH    = 6'h29,
    parameter logic [5:0] ADDR_DACCONB = 6'h2B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] io_addr,
    input  logic [7:0] io_data_in,
    output logic [7:0] io_data_out,
    input  logic       io_read,
    input  logic       io_write,
    input  logic       dac_trigger,
    output logic       dac_out,
    output logic       dac_interrupt,
    output logic [7:0] debug_state,
    output logic [9:0] debug_code
);
    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        RUN       = 2'd1,
        LOAD_WAIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic        en, ate, dacif, dacie;
    logic [2:0]  ps;
    logic        dalar;
    logic [7:0]  temp;
    logic [9:0]  buffer, active, acc;
    logic [6:0]  psc;
    logic        pending, trig_q;

    logic        mode, mode_chg, wrap_ok, pwm_bit;
    logic        wr_con, wr_conb, wr_l, wr_h;
    logic        en_next, pending_next, tick, load, request;
    logic [6:0]  psc_last;
    logic [10:0] sum;

    assign wr_con  = io_write && (io_addr == ADDR_DACCON);
    assign wr_conb = io_write && (io_addr == ADDR_DACCONB);
    assign wr_l    = io_write && (io_addr == ADDR_DACL);
    assign wr_h    = io_write && (io_addr == ADDR_DACH);

    // For DACPS=7 the shift wraps to 0, so the subtraction still yields 127.
    assign psc_last = (7'd1 << ps) - 7'd1;
    assign tick     = en && (psc >= psc_last);
    assign load     = tick && pending && wrap_ok;
    assign request  = (wr_con && io_data_in[6] && (en || io_data_in[7]))
                   || (dac_trigger && !trig_q && ate && en);
    assign sum      = {1'b0, acc} + {1'b0, active};

    always_comb begin
        en_next      = en;
        pending_next = pending;
        state_next   = state;
        if (wr_con)
            en_next = io_data_in[7];
        if (load)
            pending_next = 1'b0;
        if (request)
            pending_next = 1'b1;
        if (!en_next)
            pending_next = 1'b0;

        case (state)
            DISABLED:  if (en_next) state_next = pending_next ? LOAD_WAIT : RUN;
            RUN: begin
                if (!en_next)          state_next = DISABLED;
                else if (pending_next) state_next = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (!en_next)           state_next = DISABLED;
                else if (!pending_next) state_next = RUN;
            end
            default:   state_next = DISABLED;
        endcase
    end

`ifdef AXIOMA_DAC_PWM_EN
    logic [9:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= 1'b0;
            cnt  <= '0;
        end else begin
            if (wr_conb)
                mode <= io_data_in[0];
            if (!en_next || mode_chg)
                cnt <= '0;
            else if (tick && mode)
                cnt <= cnt + 10'd1;
        end
    end

    assign mode_chg = wr_conb && (io_data_in[0] != mode);
    assign wrap_ok  = !mode || (cnt == 10'h3FF);
    assign pwm_bit  = (cnt < active);
`else
    assign mode     = 1'b0;
    assign mode_chg = 1'b0;
    assign wrap_ok  = 1'b1;
    assign pwm_bit  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DISABLED;
            en      <= 1'b0;
            ate     <= 1'b0;
            dacif   <= 1'b0;
            dacie   <= 1'b0;
            ps      <= 3'd0;
            dalar   <= 1'b0;
            temp    <= 8'h00;
            buffer  <= '0;
            active  <= '0;
            acc     <= '0;
            psc     <= '0;
            pending <= 1'b0;
            trig_q  <= 1'b0;
            dac_out <= 1'b0;
        end else begin
            state   <= state_next;
            en      <= en_next;
            pending <= pending_next;
            trig_q  <= dac_trigger;
            if (wr_con) begin
                ate   <= io_data_in[5];
                dacie <= io_data_in[3];
                ps    <= io_data_in[2:0];
            end
            // A load in the same clk as a clear write keeps the flag set.
            if (load)
                dacif <= 1'b1;
            else if (wr_con && io_data_in[4])
                dacif <= 1'b0;
            if (wr_conb)
                dalar <= io_data_in[5];
            if (wr_h)
                temp <= io_data_in;
            if (wr_l)
                buffer <= dalar ? {temp, io_data_in[7:6]} : {temp[1:0], io_data_in};
            if (load)
                active <= buffer;
            if (!en_next || tick)
                psc <= '0;
            else
                psc <= psc + 7'd1;
            if (!en_next || mode_chg)
                acc <= '0;
            else if (tick && !mode)
                acc <= sum[9:0];
            if (!en_next)
                dac_out <= 1'b0;
            else if (tick)
                dac_out <= mode ? pwm_bit : sum[10];
        end
    end

    always_comb begin
        io_data_out = 8'h00;
        if (io_read) begin
            case (io_addr)
                ADDR_DACCON:  io_data_out = {en, pending, ate, dacif, dacie, ps};
                ADDR_DACCONB: io_data_out = {2'b00, dalar, 4'b0000, mode};
                ADDR_DACL:    io_data_out = dalar ? {buffer[1:0], 6'b000000} : buffer[7:0];
                ADDR_DACH:    io_data_out = dalar ? buffer[9:2] : {6'b000000, buffer[9:8]};
                default:      io_data_out = 8'h00;
            endcase
        end
    end

    assign dac_interrupt = dacif && dacie;
    assign debug_state   = {state, en, pending, mode, 3'b000};
    assign debug_code    = active;

endmodule
`default_nettype wire

// File: tb/tb_axioma_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_axioma_dac
// Function : scoreboard bench for axioma_dac register map, modulators, update/IRQ
// Revision : 1.0
// ============================================================================
module tb_axioma_dac;
    localparam logic [5:0] A_CON  = 6'h2A;
    localparam logic [5:0] A_L    = 6'h28;
    localparam logic [5:0] A_H    = 6'h29;
    localparam logic [5:0] A_CONB = 6'h2B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] io_addr;
    logic [7:0] io_data_in, io_data_out;
    logic       io_read, io_write, dac_trigger;
    logic       dac_out, dac_interrupt;
    logic [7:0] debug_state;
    logic [9:0] debug_code;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    axioma_dac dut (
        .clk          (clk),
        .reset        (reset),
        .io_addr      (io_addr),
        .io_data_in   (io_data_in),
        .io_data_out  (io_data_out),
        .io_read      (io_read),
        .io_write     (io_write),
        .dac_trigger  (dac_trigger),
        .dac_out      (dac_out),
        .dac_interrupt(dac_interrupt),
        .debug_state  (debug_state),
        .debug_code   (debug_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        io_addr = a; io_data_in = d; io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic rd_cmp(input logic [5:0] a);
        logic [7:0] d;
        io_addr = a; io_read = 1'b1;
        #1 d = io_data_out;
        io_read = 1'b0;
        sb_pop_check(32'(d));
        @(negedge clk);
    endtask

    task automatic count_ones(input int n, output int ones, output int flips);
        logic prev;
        ones = 0; flips = 0; prev = dac_out;
        for (int i = 0; i < n; i++) begin
            if (dac_out) ones++;
            if (i > 0 && dac_out != prev) flips++;
            prev = dac_out;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, flips, rises, t0, t1, i;
        logic prev;
        io_addr = 6'h00; io_data_in = 8'h00; io_read = 1'b0; io_write = 1'b0; dac_trigger = 1'b0;
        repeat (3) @(negedge clk);

        sb_push("rst_state", 32'h0); sb_push("rst_code", 32'h0); sb_push("rst_out", 32'h0);
        sb_pop_check(32'(debug_state)); sb_pop_check(32'(debug_code)); sb_pop_check(32'(dac_out));
        reset = 1'b0;
        @(negedge clk);

        // Code 512, sigma-delta, prescale 1
        io_wr(A_H, 8'h02);
        io_wr(A_L, 8'h00);
        sb_push("sd512_dach", 32'h02); rd_cmp(A_H);
        sb_push("sd512_dacl", 32'h00); rd_cmp(A_L);
        io_wr(A_CON, 8'hC0);
        sb_push("sd512_wait_state", 32'hB0); sb_pop_check(32'(debug_state));
        sb_push("sd512_con_pending", 32'hC0); rd_cmp(A_CON);
        sb_push("sd512_code", 32'd512); sb_pop_check(32'(debug_code));
        sb_push("sd512_run_state", 32'h60); sb_pop_check(32'(debug_state));
        sb_push("sd512_con_loaded", 32'h90); rd_cmp(A_CON);
        sb_push("sd512_ones", 32'd512); sb_push("sd512_alternate", 32'd1023);
        count_ones(1024, ones, flips);
        sb_pop_check(32'(ones)); sb_pop_check(32'(flips));

        // Reset in the middle of a run
        reset = 1'b1;
        #1;
        sb_push("mrst_out", 32'h0); sb_push("mrst_code", 32'h0); sb_push("mrst_irq", 32'h0);
        sb_pop_check(32'(dac_out)); sb_pop_check(32'(debug_code)); sb_pop_check(32'(dac_interrupt));
        @(negedge clk);
        sb_push("mrst_con", 32'h0);  rd_cmp(A_CON);
        sb_push("mrst_conb", 32'h0); rd_cmp(A_CONB);
        sb_push("mrst_dacl", 32'h0); rd_cmp(A_L);
        sb_push("mrst_dach", 32'h0); rd_cmp(A_H);
        reset = 1'b0;
        @(negedge clk);

        // Left-adjusted code 1023
        io_wr(A_CONB, 8'h20);
        io_wr(A_H, 8'hFF);
        io_wr(A_L, 8'hC0);
        sb_push("la_dach", 32'hFF);  rd_cmp(A_H);
        sb_push("la_dacl", 32'hC0);  rd_cmp(A_L);
        sb_push("la_conb", 32'h20);  rd_cmp(A_CONB);
        io_wr(A_CON, 8'hC0);
        @(negedge clk);
        sb_push("la_code", 32'd1023); sb_pop_check(32'(debug_code));
        @(negedge clk);
        sb_push("la_ones", 32'd1023);
        count_ones(1024, ones, flips);
        sb_pop_check(32'(ones));

        io_wr(A_CON, 8'h00);
`ifdef AXIOMA_DAC_PWM_EN
        io_wr(A_CONB, 8'h01);
        io_wr(A_H, 8'h01);
        io_wr(A_L, 8'h00);
        io_wr(A_CON, 8'hC1);
        sb_push("pwm_load1", 32'd256);
        for (i = 0; i < 5000 && debug_code != 10'd256; i++) @(negedge clk);
        sb_pop_check(32'(debug_code));
        t0 = cyc;
        sb_push("pwm_ones256", 32'd512);
        count_ones(2048, ones, flips);
        sb_pop_check(32'(ones));
        repeat (1024) @(negedge clk);
        io_wr(A_H, 8'h03);
        io_wr(A_L, 8'h00);
        io_wr(A_CON, 8'hC1);
        sb_push("pwm_hold_code", 32'd256); sb_pop_check(32'(debug_code));
        sb_push("pwm_con_pending", 32'hD1); rd_cmp(A_CON);
        sb_push("pwm_load2", 32'd768);
        for (i = 0; i < 5000 && debug_code != 10'd768; i++) @(negedge clk);
        sb_pop_check(32'(debug_code));
        t1 = cyc;
        sb_push("pwm_load_at_wrap", 32'd4096); sb_pop_check(32'(t1 - t0));
        io_wr(A_CON, 8'h00);
`else
        io_wr(A_CONB, 8'h21);
        sb_push("conb_mode_tied", 32'h20); rd_cmp(A_CONB);
`endif
        io_wr(A_CONB, 8'h00);

        // Auto-update trigger and interrupt
        io_wr(A_H, 8'h00);
        io_wr(A_L, 8'h55);
        io_wr(A_CON, 8'hB8);
        sb_push("trg_irq_cleared", 32'h0); sb_pop_check(32'(dac_interrupt));
        sb_push("trg_one_load", 32'd1);
        rises = 0; prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            dac_trigger = (k < 3);
            @(negedge clk);
            if (debug_state[4] && !prev) rises++;
            prev = debug_state[4];
        end
        sb_pop_check(32'(rises));
        sb_push("trg_code", 32'h55); sb_pop_check(32'(debug_code));
        sb_push("trg_irq", 32'h1);   sb_pop_check(32'(dac_interrupt));
        io_wr(A_CON, 8'hB8);
        sb_push("trg_irq_drop", 32'h0); sb_pop_check(32'(dac_interrupt));

        // Clear write landing on the load clk
        io_wr(A_L, 8'h33);
        io_addr = A_CON; io_data_in = 8'hC8; io_write = 1'b1;
        @(negedge clk);
        io_data_in = 8'h98;
        @(negedge clk);
        io_write = 1'b0;
        sb_push("setwin_irq", 32'h1);  sb_pop_check(32'(dac_interrupt));
        sb_push("setwin_code", 32'h33); sb_pop_check(32'(debug_code));
        sb_push("setwin_con", 32'h98); rd_cmp(A_CON);

        // Disable while an update is pending
        io_wr(A_H, 8'h02);
        io_wr(A_L, 8'hAA);
        io_wr(A_CON, 8'hC7);
        sb_push("dis_pending", 32'hB0); sb_pop_check(32'(debug_state));
        io_wr(A_CON, 8'h07);
        sb_push("dis_state", 32'h00); sb_pop_check(32'(debug_state));
        sb_push("dis_out", 32'h0);    sb_pop_check(32'(dac_out));
        sb_push("dis_code", 32'h33);  sb_pop_check(32'(debug_code));
        sb_push("dis_con", 32'h17);   rd_cmp(A_CON);
        repeat (200) @(negedge clk);
        sb_push("dis_code_kept", 32'h33); sb_pop_check(32'(debug_code));

        // Unmapped access and idle read port
        io_wr(6'h2C, 8'hFF);
        sb_push("unmap_con", 32'h17); rd_cmp(A_CON);
        sb_push("unmap_rd", 32'h00);  rd_cmp(6'h2C);
        io_addr = A_CON; io_read = 1'b0;
        #1;
        sb_push("noread_zero", 32'h00); sb_pop_check(32'(io_data_out));

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
